// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller: 3-bit state encoding,
// opcode constants and a small opcode classification helper.
package fetch_controller_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        FETCH2 = 3'd4,
        JUMP   = 3'd5,
        HALT   = 3'd6
    } fetchState_t;

    localparam logic [3:0] OP_JC   = 4'b1000;
    localparam logic [3:0] OP_JNC  = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b1010;
    localparam logic [3:0] OP_JNZ  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // True for the four flag-conditional jump opcodes (1000..1011).
    function automatic logic isCondOp(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/fetch_controller_jump_cond.sv
// Combinational jump classifier: decides whether an opcode is a two-byte
// jump and whether that jump is taken given the ALU flags.
// Optional feature macro: FETCH_COND_JUMP_EN enables JC/JNC/JZ/JNZ; without
// it only JMP is a jump and the flags are not consulted.
import fetch_controller_pkg::*;

module jump_cond (
    input  logic [3:0] instr,
    input  logic       c_flag,
    input  logic       z_flag,
    output logic       is_jump,
    output logic       taken
);

`ifndef FETCH_COND_JUMP_EN
    // Flags have no consumer when conditional jumps are compiled out.
    logic unusedFlags;
    assign unusedFlags = c_flag ^ z_flag;
`endif

    // Classify the opcode and evaluate its branch condition.
    always_comb begin
        is_jump = 1'b0;
        taken   = 1'b0;
        case (instr)
            OP_JMP: begin
                is_jump = 1'b1;
                taken   = 1'b1;
            end
`ifdef FETCH_COND_JUMP_EN
            OP_JC: begin
                is_jump = 1'b1;
                taken   = c_flag;
            end
            OP_JNC: begin
                is_jump = 1'b1;
                taken   = ~c_flag;
            end
            OP_JZ: begin
                is_jump = 1'b1;
                taken   = z_flag;
            end
            OP_JNZ: begin
                is_jump = 1'b1;
                taken   = ~z_flag;
            end
`endif
            default: begin
                is_jump = 1'b0;
                taken   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch/decode sequencer. Drives the PC (increment/load) and the
// external fetch register, issues one-cycle ALU execute strobes, and parks in
// HALT on opcode 1111 until reset. All outputs are decoded from the state and
// the captured jump registers; instr/oprnd come from the external fetch
// register, which only changes on enableF.
// Optional feature macro: FETCH_COND_JUMP_EN (conditional jumps). Without it
// opcodes 1000..1011 are one-byte NOPs.
// stateDbg exposes the current state for observation.
import fetch_controller_pkg::*;

module fetch_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [3:0]  instr,
    input  logic [3:0]  oprnd,
    input  logic        c_flag,
    input  logic        z_flag,
    output logic        enableC,
    output logic        loadC,
    output logic [11:0] inC,
    output logic        enableF,
    output logic        exec,
    output logic [3:0]  aluop,
    output logic [3:0]  aluarg,
    output logic        halted,
    output logic [2:0]  stateDbg
);

    fetchState_t state;
    fetchState_t stateNext;
    logic [3:0]  hi;
    logic        taken;
    logic        isJump;
    logic        jumpTaken;

    jump_cond uJumpCond (
        .instr   (instr),
        .c_flag  (c_flag),
        .z_flag  (z_flag),
        .is_jump (isJump),
        .taken   (jumpTaken)
    );

    assign stateDbg = state;

    // State register plus jump high-address nibble and taken flag, both
    // captured while the opcode byte is being decoded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi    <= 4'h0;
            taken <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == DECODE) begin
                hi    <= oprnd;
                taken <= jumpTaken;
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        stateNext = state;
        enableC   = 1'b0;
        loadC     = 1'b0;
        inC       = 12'h000;
        enableF   = 1'b0;
        exec      = 1'b0;
        aluop     = 4'h0;
        aluarg    = 4'h0;
        halted    = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                enableF   = 1'b1;
                stateNext = DECODE;
            end
            DECODE: begin
                // PC steps past the opcode byte regardless of opcode.
                enableC = 1'b1;
                if (instr == OP_HALT) begin
                    stateNext = HALT;
                end else if (isJump) begin
                    stateNext = FETCH2;
                end else if (isCondOp(instr)) begin
                    // Only reachable with conditional jumps compiled out.
                    stateNext = FETCH;
                end else begin
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                exec      = 1'b1;
                aluop     = instr;
                aluarg    = oprnd;
                stateNext = FETCH;
            end
            FETCH2: begin
                enableF   = 1'b1;
                stateNext = JUMP;
            end
            JUMP: begin
                // Fetch register now holds the address byte.
                if (taken) begin
                    loadC = 1'b1;
                    inC   = {hi, instr, oprnd};
                end else begin
                    enableC = 1'b1;
                end
                stateNext = FETCH;
            end
            HALT: begin
                halted    = 1'b1;
                stateNext = HALT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
